// File: rtl/pe_pkg.sv
// pe_pkg: shared state encodings, data width and BRAM address-width helper
// used by the PE controller and the result write-back engine.
package pe_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_DONE = 2'd2} state_t;
  localparam int DATA_W = 32;
  function automatic int aw_f(input int l_ram_size);
    return 2 * l_ram_size + 1;
  endfunction
endpackage

// File: rtl/pe_wb_mux.sv
// pe_wb_mux: registered N:1 word selector feeding the BRAM write-data path.
module pe_wb_mux import pe_pkg::*; #(
  parameter int N = 16,
  localparam int SW = $clog2(N)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                ld,
  input  logic [SW-1:0]       sel,
  input  logic [DATA_W*N-1:0] bank,
  output logic [DATA_W-1:0]   q
);
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) q <= '0;
    else if (ld) q <= bank[DATA_W*sel +: DATA_W];
endmodule

// File: rtl/pe_wb_ctrl.sv
// pe_wb_ctrl: captures the PE results and serialises them into granted BRAM word writes.
// Optional PE_WB_CHECKSUM_EN appends a wrapping 32-bit sum of the words as one extra write.
module pe_wb_ctrl import pe_pkg::*; #(
  parameter int VECTOR_SIZE = 4,
  parameter int L_RAM_SIZE = 6,
  localparam int N = 2**VECTOR_SIZE,
  localparam int AW = aw_f(L_RAM_SIZE)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic [DATA_W*N-1:0] res_data,
  input  logic [AW-1:0]       wrbase,
  input  logic                bram_gnt,
  output logic                bram_en,
  output logic [3:0]          bram_we,
  output logic [AW-1:0]       bram_addr,
  output logic [DATA_W-1:0]   bram_wrdata,
`ifdef PE_WB_CHECKSUM_EN
  output logic [DATA_W-1:0]   checksum,
`endif
  output logic                busy,
  output logic                done
);
`ifdef PE_WB_CHECKSUM_EN
  localparam logic [VECTOR_SIZE:0] LAST = (VECTOR_SIZE+1)'(N);
`else
  localparam logic [VECTOR_SIZE:0] LAST = (VECTOR_SIZE+1)'(N - 1);
`endif
  state_t state, nxt;
  logic [VECTOR_SIZE:0] cnt;
  logic [VECTOR_SIZE-1:0] sel;
  logic [AW-1:0] addr_q;
  logic [DATA_W*N-1:0] cap;
  logic [DATA_W-1:0] word_q;
  logic acc, wr;
  assign acc = state == S_IDLE && start;
  assign wr = state == S_WRITE && bram_gnt;
  always_comb nxt = acc ? S_WRITE : (wr && cnt == LAST) ? S_DONE : state == S_DONE ? S_IDLE : state;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= S_IDLE;
    else state <= nxt;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      cap <= '0;
      cnt <= '0;
      addr_q <= '0;
    end else if (acc) begin
      cap <= res_data;
      cnt <= '0;
      addr_q <= wrbase;
    end else if (wr) begin
      cnt <= cnt + (VECTOR_SIZE+1)'(1);
      addr_q <= addr_q + AW'(1);
    end
  // The word register is loaded one write ahead, straight from res_data on the capture cycle
  assign sel = acc ? '0 : cnt[VECTOR_SIZE-1:0] + VECTOR_SIZE'(1);
  pe_wb_mux #(.N(N)) u_mux (
    .aclk   (aclk),
    .aresetn(aresetn),
    .ld     (acc || wr),
    .sel    (sel),
    .bank   (acc ? res_data : cap),
    .q      (word_q)
  );
  assign bram_en = wr;
  assign bram_we = {4{wr}};
  assign bram_addr = addr_q;
  assign busy = state == S_WRITE;
  assign done = state == S_DONE;
`ifdef PE_WB_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) sum_q <= '0;
    else if (acc) sum_q <= '0;
    else if (wr && !cnt[VECTOR_SIZE]) sum_q <= sum_q + word_q;
  assign bram_wrdata = cnt[VECTOR_SIZE] ? sum_q : word_q;
  assign checksum = sum_q;
`else
  assign bram_wrdata = word_q;
`endif
endmodule

// File: tb/tb_pe_wb_ctrl.sv
// tb_pe_wb_ctrl: table-driven and randomised check of pe_wb_ctrl against an
// ordered expected-write model (base+i, word i, optional checksum word).
module tb_pe_wb_ctrl;
  import pe_pkg::*;
  localparam int N = 16, AW = 13;
`ifdef PE_WB_CHECKSUM_EN
  localparam int NW = N + 1;
`else
  localparam int NW = N;
`endif
  typedef struct {
    logic [AW-1:0] base;
    int stall_at;
    int stall_len;
    int gmode;
    bit noise;
    int dsel;
    int exp_done;
  } vec_t;
  logic aclk = 0, aresetn = 1, start = 0, bram_gnt = 0;
  logic [32*N-1:0] res_data = '0;
  logic [AW-1:0] wrbase = '0;
  logic bram_en, busy, done;
  logic [3:0] bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0] bram_wrdata;
`ifdef PE_WB_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  logic [31:0] words [N];
  int checks = 0, failures = 0;
  vec_t tbl [5];
  always #5 aclk = ~aclk;
  pe_wb_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .res_data(res_data), .wrbase(wrbase),
    .bram_gnt(bram_gnt), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wrdata(bram_wrdata),
`ifdef PE_WB_CHECKSUM_EN
    .checksum(checksum),
`endif
    .busy(busy), .done(done)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic fill(input int dsel);
    for (int i = 0; i < N; i++) words[i] = dsel == 0 ? 32'hA000_0000 + i : dsel == 2 ? i + 1 : $urandom;
  endtask
  // gmode: 0 grant always, 1 stall once at stall_at, 2 random grant, 3 grant on odd cycles
  task automatic run(input vec_t v);
    logic [31:0] sum = 0;
    logic [AW-1:0] a;
    int nwr = 0, gcnt = 0, stalled = 0, done_cyc = -1, exp_cyc = 0;
    fill(v.dsel);
    @(negedge aclk);
    for (int i = 0; i < N; i++) begin
      res_data[32*i +: 32] = words[i];
      sum += words[i];
    end
    wrbase = v.base;
    start = 1;
    @(negedge aclk);
    start = 0;
    for (int cyc = 1; cyc < 400 && done_cyc < 0; cyc++) begin
      bram_gnt = v.gmode == 2 ? 1'($urandom_range(0, 1)) : v.gmode == 3 ? cyc[0] :
                 !(v.gmode == 1 && gcnt == v.stall_at && stalled < v.stall_len);
      if (v.gmode == 1 && !bram_gnt) stalled++;
      if (v.noise) begin
        for (int i = 0; i < N; i++) res_data[32*i +: 32] = $urandom;
        wrbase = AW'($urandom);
        start = cyc == 3;
      end
      #1;
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
        chk("we_at_done", bram_we, 0);
        chk("en_at_done", bram_en, 0);
        start = 1;
      end else begin
        if (bram_gnt) begin
          gcnt++;
          if (gcnt == NW) exp_cyc = cyc + 1;
        end
        a = v.base + AW'(nwr);
        chk("busy", busy, 1);
        chk("addr", bram_addr, a);
        chk("data", bram_wrdata, nwr < N ? words[nwr] : sum);
        chk("we", bram_we, bram_gnt ? 4'hF : 4'h0);
        if (bram_gnt) begin
          chk("en", bram_en, 1);
          nwr++;
        end
      end
      @(negedge aclk);
    end
    start = 0;
    bram_gnt = 0;
    #1;
    chk("start_in_done_ignored", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("write_count", nwr, NW);
    chk("done_cycle_model", done_cyc, exp_cyc);
    if (v.exp_done > 0) chk("done_cycle_table", done_cyc, v.exp_done);
`ifdef PE_WB_CHECKSUM_EN
    chk("checksum", checksum, sum);
`endif
  endtask
  initial begin
    vec_t r;
    #2 aresetn = 0;
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_en", bram_en, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_data", bram_wrdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef PE_WB_CHECKSUM_EN
    chk("rst_checksum", checksum, 0);
`endif
    aresetn = 1;
    tbl[0] = '{13'h0100, -1, 0, 0, 1'b0, 0, NW + 1};
    tbl[1] = '{13'h0100, 5, 3, 1, 1'b0, 0, NW + 4};
    tbl[2] = '{13'h1FFE, -1, 0, 0, 1'b0, 1, NW + 1};
    tbl[3] = '{13'h00AA, -1, 0, 0, 1'b1, 2, NW + 1};
    tbl[4] = '{13'h0040, -1, 0, 3, 1'b0, 1, 2 * NW};
    for (int k = 0; k < 5; k++) run(tbl[k]);
    for (int k = 0; k < 6; k++) begin
      r = '{AW'($urandom), -1, 0, 2, 1'($urandom_range(0, 1)), 1, 0};
      run(r);
    end
    // reset in the middle of a write-back
    fill(1);
    @(negedge aclk);
    for (int i = 0; i < N; i++) res_data[32*i +: 32] = words[i];
    wrbase = 13'h0200;
    start = 1;
    @(negedge aclk);
    start = 0;
    bram_gnt = 1;
    repeat (3) @(negedge aclk);
    #1;
    chk("abort_pre_addr", bram_addr, 13'h0203);
    @(negedge aclk);
    aresetn = 0;
    #1;
    chk("abort_en", bram_en, 0);
    chk("abort_we", bram_we, 0);
    chk("abort_addr", bram_addr, 0);
    chk("abort_data", bram_wrdata, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3) begin
      @(negedge aclk);
      #1;
      chk("abort_no_done", done, 0);
      chk("abort_no_write", bram_we, 0);
    end
    aresetn = 1;
    bram_gnt = 0;
    run('{13'h0300, -1, 0, 0, 1'b0, 0, NW + 1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
